// File: rtl/gpr_ctx_mover.sv
// gpr_ctx_mover: bus master copying x1..x31 to/from the ROM GPR window.
// Ports: clk/rst, save_req/restore_req, busy/done, mem_* bus, rf_* port.
module gpr_ctx_mover #(
  parameter logic [31:0] GPR_BASE  = 32'hffffc000,
  parameter int          FIRST_REG = 1,
  parameter int          LAST_REG  = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        save_req,
  input  logic        restore_req,
  output logic        busy,
  output logic        done,
  output logic        mem_req,
  input  logic        bus_gnt,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  inout  wire  [31:0] mem_data,
  output logic [4:0]  rf_addr,
  input  logic [31:0] rf_rdata,
  output logic        rf_we,
  output logic [31:0] rf_wdata
);

  typedef enum logic [1:0] {
    IDLE,
    SAVE,
    RESTORE,
    DONE
  } state_e;

  localparam logic [4:0] FIRST = 5'(FIRST_REG);
  localparam logic [4:0] LAST  = 5'(LAST_REG);

  state_e      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [31:0] slot_addr;
  logic        rd_sel;

  assign slot_addr = GPR_BASE | {25'b0, idx_q, 2'b00};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= FIRST;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    busy     = 1'b0;
    done     = 1'b0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    rf_addr  = '0;
    rf_we    = 1'b0;
    rd_sel   = 1'b0;
    unique case (state_q)
      IDLE: begin
        idx_d = FIRST;
        if (save_req) begin
          state_d = SAVE;
        end else if (restore_req) begin
          state_d = RESTORE;
        end
      end
      SAVE, RESTORE: begin
        busy     = 1'b1;
        mem_req  = 1'b1;
        mem_addr = slot_addr;
        rf_addr  = idx_q;
        rd_sel   = (state_q == RESTORE);
        if (bus_gnt) begin
          mem_we = (state_q == SAVE);
          rf_we  = (state_q == RESTORE);
          // hold at the last index instead of wrapping
          if (idx_q == LAST) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
    endcase
    // a low reset kills the current beat so no slot or register is touched
    if (!rst) begin
      busy     = 1'b0;
      done     = 1'b0;
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      mem_addr = '0;
      rf_addr  = '0;
      rf_we    = 1'b0;
      rd_sel   = 1'b0;
    end
  end

  assign mem_data = mem_we ? rf_rdata : 'z;
  assign rf_wdata = rd_sel ? mem_data : '0;

endmodule

// File: tb/tb_gpr_ctx_mover.sv
// tb_gpr_ctx_mover: scoreboard bench with ROM and register-file models.
// Stimulus pushes expected beats; a negedge monitor pops and compares.
module tb_gpr_ctx_mover;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        save_req = 1'b0;
  logic        restore_req = 1'b0;
  logic        bus_gnt = 1'b1;
  logic        busy, done, mem_req, mem_we, rf_we;
  logic [31:0] mem_addr, rf_rdata, rf_wdata;
  logic [4:0]  rf_addr;
  wire  [31:0] mem_data;

  gpr_ctx_mover dut (
    .clk        (clk),
    .rst        (rst),
    .save_req   (save_req),
    .restore_req(restore_req),
    .busy       (busy),
    .done       (done),
    .mem_req    (mem_req),
    .bus_gnt    (bus_gnt),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .rf_addr    (rf_addr),
    .rf_rdata   (rf_rdata),
    .rf_we      (rf_we),
    .rf_wdata   (rf_wdata)
  );

  always #5 clk = ~clk;

  logic [31:0] rom [32];
  logic [31:0] rf  [32];
  logic        rom_ld = 1'b0, rf_ld = 1'b0;
  logic [31:0] rom_ld_base = '0, rf_ld_base = '0;
  logic        rom_oe;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          mon_on = 1'b0;

  assign rom_oe   = mem_req && bus_gnt && !mem_we;
  assign mem_data = rom_oe ? rom[mem_addr[6:2]] : 'z;
  assign rf_rdata = rf[rf_addr];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rom_ld) begin
      for (int i = 0; i < 32; i++) rom[i] <= rom_ld_base + i;
    end else if (mem_we) begin
      rom[mem_addr[6:2]] <= mem_data;
    end
    if (rf_ld) begin
      for (int i = 0; i < 32; i++) rf[i] <= rf_ld_base + i;
    end else if (rf_we) begin
      rf[rf_addr] <= rf_wdata;
    end
  end

  typedef struct {
    int          kind;
    int          idx;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cyc %0d)", nm, got, want, cyc);
    end
  endtask

  task automatic check_txn(input int kind);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_beat: got kind %0d at cyc %0d want none",
               kind, cyc);
      return;
    end
    e = exp_q.pop_front();
    chk("beat_kind", 32'(kind), 32'(e.kind));
    chk("beat_cycle", 32'(cyc), 32'(e.cyc));
    if (kind == 0) begin
      chk("save_addr", mem_addr, 32'hffffc000 + 32'(4 * e.idx));
      chk("save_rfidx", 32'(rf_addr), 32'(e.idx));
      chk("save_data", mem_data, e.data);
    end else if (kind == 1) begin
      chk("rest_addr", mem_addr, 32'hffffc000 + 32'(4 * e.idx));
      chk("rest_rfidx", 32'(rf_addr), 32'(e.idx));
      chk("rest_data", rf_wdata, e.data);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      if (mem_we && rf_we) chk("we_exclusive", 32'd1, 32'd0);
      if (rf_we && !bus_gnt) chk("rf_we_no_gnt", 32'd1, 32'd0);
      if (mem_we) check_txn(0);
      if (rf_we) check_txn(1);
      if (done) check_txn(2);
      if (!busy) begin
        chk("idle_addr", mem_addr, 32'd0);
        chk("idle_ctl", {24'd0, rf_addr, mem_req, mem_we, rf_we}, 32'd0);
        chk("idle_wdata", rf_wdata, 32'd0);
      end
      if (!mem_we && !rom_oe) begin
        n_cmp++;
        if (!(mem_data === 32'bz || mem_data === 32'd0)) begin
          n_bad++;
          $display("FAIL bus_released: got %h want z", mem_data);
        end
      end
    end
  end

  task automatic load_rf(input logic [31:0] base);
    rf_ld_base = base;
    rf_ld = 1'b1;
    @(posedge clk);
    #1 rf_ld = 1'b0;
  endtask

  task automatic load_rom(input logic [31:0] base);
    rom_ld_base = base;
    rom_ld = 1'b1;
    @(posedge clk);
    #1 rom_ld = 1'b0;
  endtask

  // run one operation; cycle k is the k-th cycle after the request edge
  task automatic run_op(input bit sv, input bit rs, input logic [31:0] base,
                        input int slo, input int shi, input int rst_at,
                        input int pulse_at);
    exp_t e;
    int   c;
    int   kend;
    bit   cut;
    @(negedge clk);
    c = 1;
    cut = 1'b0;
    for (int i = 1; i <= 31; i++) begin
      while (c >= slo && c <= shi) c++;
      if (rst_at != 0 && c >= rst_at) cut = 1'b1;
      if (!cut) begin
        e.kind = sv ? 0 : 1;
        e.idx  = i;
        e.data = base + 32'(i);
        e.cyc  = cyc + c;
        exp_q.push_back(e);
      end
      c++;
    end
    if (!cut) begin
      e.kind = 2;
      e.idx  = 0;
      e.data = '0;
      e.cyc  = cyc + c;
      exp_q.push_back(e);
      kend = c + 1;
    end else begin
      kend = rst_at + 1;
    end
    save_req = sv;
    restore_req = rs;
    @(posedge clk);
    #1;
    save_req = 1'b0;
    restore_req = 1'b0;
    for (int k = 1; k <= kend; k++) begin
      bus_gnt = !(k >= slo && k <= shi);
      rst = !(k == rst_at);
      restore_req = (k == pulse_at);
      @(negedge clk);
      #1;
      if (k == kend) begin
        chk("end_idle", {27'd0, busy, done, mem_req, mem_we, rf_we}, 32'd0);
        chk("end_addr", mem_addr, 32'd0);
      end
      @(posedge clk);
      #1;
    end
    bus_gnt = 1'b1;
    rst = 1'b1;
    restore_req = 1'b0;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic check_rom(input logic [31:0] lo_base, input int split,
                           input logic [31:0] hi_base);
    for (int i = 1; i <= 31; i++) begin
      chk($sformatf("rom_slot%0d", i), rom[i],
          (i < split) ? lo_base + 32'(i) : hi_base + 32'(i));
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", {27'd0, busy, done, mem_req, mem_we, rf_we}, 32'd0);
    chk("reset_addr", mem_addr, 32'd0);
    rst = 1'b1;
    load_rf(32'hA5000000);
    load_rom(32'h11110000);
    mon_on = 1'b1;

    // plain save, grant always high
    run_op(1'b1, 1'b0, 32'hA5000000, 0, -1, 0, 0);
    check_rom(32'hA5000000, 32, 32'h0);

    // plain restore; x0 must keep its old value
    load_rom(32'h5A5A0000);
    run_op(1'b0, 1'b1, 32'h5A5A0000, 0, -1, 0, 0);
    for (int i = 1; i <= 31; i++)
      chk($sformatf("rf_x%0d", i), rf[i], 32'h5A5A0000 + 32'(i));
    chk("rf_x0_kept", rf[0], 32'hA5000000);

    // grant low in cycles 5..7
    load_rom(32'h11110000);
    run_op(1'b1, 1'b0, 32'h5A5A0000, 5, 7, 0, 0);
    check_rom(32'h5A5A0000, 32, 32'h0);

    // both requests together: save wins
    load_rf(32'h3C000000);
    run_op(1'b1, 1'b1, 32'h3C000000, 0, -1, 0, 0);
    check_rom(32'h3C000000, 32, 32'h0);

    // restore pulse mid-save is ignored
    load_rf(32'h77000000);
    run_op(1'b1, 1'b0, 32'h77000000, 0, -1, 0, 10);
    check_rom(32'h77000000, 32, 32'h0);

    // reset in cycle 10 of a save
    load_rf(32'hC3000000);
    run_op(1'b1, 1'b0, 32'hC3000000, 0, -1, 10, 0);
    check_rom(32'hC3000000, 10, 32'h77000000);

    // fresh save after the abort restarts at x1
    run_op(1'b1, 1'b0, 32'hC3000000, 0, -1, 0, 0);
    check_rom(32'hC3000000, 32, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gpr_ctx_mover.md
Name: gpr_ctx_mover

Overview:
- Bus master that bulk-copies core registers x1..x31 to or from the GPR window of the memory-mapped ROM/scratch block (base 0xffffc000, word-addressed).
- Sits directly upstream of that block on its shared bus (mem_we / mem_addr / bidirectional mem_data).
- Used on trap entry (save) and trap return (restore); a bus arbiter gates it via bus_gnt.
- Sequential: 4-state FSM plus a 5-bit register-index counter with grant stalls.

Parameters:
- GPR_BASE, 32'hffffc000, byte address of GPR slot 0 in the ROM block.
- FIRST_REG, 1, first register index moved; x0 is never moved.
- LAST_REG, 31, last register index moved.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-low.
- save_req  in  1  start save (core regs -> ROM); sampled only in IDLE.
- restore_req  in  1  start restore (ROM -> core regs); sampled only in IDLE.
- busy  out  1  high in SAVE, RESTORE and DONE.
- done  out  1  one-cycle pulse on completion.
- mem_req  out  1  bus request to arbiter.
- bus_gnt  in  1  arbiter grant; the bus may be used only in a cycle where this is high.
- mem_we  out  1  ROM write enable.
- mem_addr  out  32  ROM byte address.
- mem_data  inout  32  shared data bus; driven only when mem_we=1, else high-Z.
- rf_addr  out  5  register-file index.
- rf_rdata  in  32  register-file combinational read data for rf_addr.
- rf_we  out  1  register-file write enable; written at posedge.
- rf_wdata  out  32  register-file write data.

Behaviour:
- Reset (rst=0 at posedge): state=IDLE, idx=FIRST_REG.
  - Outputs held at: busy=0, done=0, mem_req=0, mem_we=0, mem_addr=0, rf_we=0, rf_addr=0, rf_wdata=0, mem_data=Z.
  - Reset mid-transfer aborts immediately; there is no resume. Already-written slots keep their data.
- Bus timing: the ROM read is combinational (data valid in the same cycle as the address with mem_we=0). A ROM write commits at the posedge while mem_we=1.
- IDLE:
  - save_req=1 -> SAVE; else restore_req=1 -> RESTORE. Save wins if both are high.
  - idx loads FIRST_REG.
- SAVE:
  - mem_req=1, rf_addr=idx, mem_addr=GPR_BASE+{idx,2'b00}.
  - If bus_gnt=1: mem_we=1, mem_data=rf_rdata, idx increments at posedge.
  - If bus_gnt=0: mem_we=0, mem_data=Z, idx holds.
  - Granted cycle with idx=LAST_REG -> DONE.
- RESTORE:
  - mem_req=1, mem_we=0, mem_addr as in SAVE, rf_addr=idx, rf_wdata=mem_data.
  - rf_we=bus_gnt; idx increments on granted cycles.
  - Granted cycle with idx=LAST_REG -> DONE.
- DONE: one cycle; done=1, busy=1, mem_req=0, mem_we=0, rf_we=0 -> IDLE.
- Latency with bus_gnt held at 1: req sampled at edge 0; transfer cycles 1..31; done in cycle 32; IDLE in cycle 33. Each low-grant cycle adds exactly one cycle.
- Requests arriving while busy=1 are ignored and are not queued.
- Address arithmetic: idx is 5-bit; the address is GPR_BASE OR'd with idx<<2. No address outside 0xffffc004..0xffffc07c is ever issued.
- idx never wraps; the FSM exits at LAST_REG.
- rf_we and mem_we are never high in the same cycle.
- Outside SAVE/RESTORE, mem_addr=0 and mem_we=0.

Test Plan:
- Save, gnt=1: rf x_i=0xA5000000+i -> 31 writes at addr 0xffffc004..0xffffc07c, data 0xA5000001..0xA500001F; done pulses in cycle 32; ROM reads back identically.
- Restore, gnt=1: ROM GPR slot i=0x5A5A0000+i -> rf_we 31 cycles, rf x_i=0x5A5A0000+i; x0 never written; done in cycle 32.
- Grant stall: save with bus_gnt low on cycles 5-7 -> mem_we=0 and mem_data=Z in those cycles; idx holds; no duplicate or skipped address; done in cycle 35.
- Simultaneous save_req=restore_req=1 in IDLE -> save performed; the restore request is dropped.
- restore_req pulsed mid-save -> ignored; exactly one done pulse.
- rst=0 at cycle 10 of save -> next cycle all outputs at reset values; slots 1..9 hold new data, slots 10..31 are unchanged; a new save_req afterwards starts at idx 1.
